// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller: samples, then resolves one bit per
// step from MSB to LSB using an external DAC + comparator, and reports the code.
module sar_adc_ctrl #(
  parameter int NBITS      = 12,
  parameter int SAMPLE_CYC = 2,
  parameter int SETTLE     = 1
) (
  input  logic             CK,
  input  logic             RSTN,
  input  logic             START,
  input  logic             CMP,
  output logic             SAMPLE,
  output logic             BUSY,
  output logic [NBITS-1:0] DACODE,
  output logic [NBITS-1:0] DOUT,
  output logic             DVALID,
  output logic             OVR
);

  localparam int CNT_MAX = (SAMPLE_CYC > SETTLE + 1) ? SAMPLE_CYC : SETTLE + 1;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = $clog2(NBITS);

  localparam logic [CNT_W-1:0] SAMP_LAST   = CNT_W'(SAMPLE_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE);
  localparam logic [IDX_W-1:0] IDX_MSB     = IDX_W'(NBITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SAMP = 2'd1,
    CONV = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             sample_q, sample_d;
  logic             busy_q, busy_d;
  logic [NBITS-1:0] dacode_q, dacode_d;
  logic [NBITS-1:0] dout_q, dout_d;
  logic             dvalid_q, dvalid_d;
  logic             ovr_q, ovr_d;

  // The trial code doubles as the working result: bits above idx_q are
  // resolved, bit idx_q is the bit under trial, bits below are still zero.
  always_comb begin
    // NOTE: every _d gets a default before the case so no path infers a latch;
    // blocking assignments here are intentional, dacode_d is re-read below.
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    sample_d = sample_q;
    busy_d   = busy_q;
    dacode_d = dacode_q;
    dout_d   = dout_q;
    dvalid_d = 1'b0;
    ovr_d    = START & busy_q;

    case (state_q)
      IDLE: begin
        if (START) begin
          state_d  = SAMP;
          sample_d = 1'b1;
          busy_d   = 1'b1;
          cnt_d    = '0;
        end
      end
      SAMP: begin
        if (cnt_q == SAMP_LAST) begin
          state_d             = CONV;
          sample_d            = 1'b0;
          cnt_d               = '0;
          idx_d               = IDX_MSB;
          dacode_d            = '0;
          dacode_d[NBITS-1]   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      CONV: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d           = '0;
          dacode_d[idx_q] = CMP;
          if (idx_q == '0) begin
            state_d  = IDLE;
            busy_d   = 1'b0;
            dvalid_d = 1'b1;
            dout_d   = dacode_d;
          end else begin
            idx_d                          = idx_q - IDX_W'(1);
            dacode_d[idx_q - IDX_W'(1)]    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d  = IDLE;
        sample_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      sample_q <= 1'b0;
      busy_q   <= 1'b0;
      dacode_q <= '0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking for all state so every flop samples pre-edge values.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      sample_q <= sample_d;
      busy_q   <= busy_d;
      dacode_q <= dacode_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      ovr_q    <= ovr_d;
    end
  end

  assign SAMPLE = sample_q;
  assign BUSY   = busy_q;
  assign DACODE = dacode_q;
  assign DOUT   = dout_q;
  assign DVALID = dvalid_q;
  assign OVR    = ovr_q;

endmodule
